// File: rtl/stack_pop_if.sv
// ---------------------------------------------------------------------------
// stack_pop_if
// Read port between the stack-pop assembler and the memory-stage data memory.
//   mem_rd_en  assembler -> memory  : read request; beat accepted on rd_en && valid
//   mem_valid  memory -> assembler  : mem_data carries a popped word this cycle
//   mem_data   memory -> assembler  : popped stack word, BUS_W bits
// Modports: master = assembler side, slave = memory side.
// ---------------------------------------------------------------------------
interface stack_pop_if #(
    parameter int BUS_W = 16
) ();
    logic             mem_rd_en;
    logic             mem_valid;
    logic [BUS_W-1:0] mem_data;

    modport master (output mem_rd_en, input mem_valid, input mem_data);
    modport slave  (input mem_rd_en, output mem_valid, output mem_data);
endinterface

// File: rtl/stack_pop_assembler.sv
// ---------------------------------------------------------------------------
// stack_pop_assembler
// Collects a multi-beat value popped from the data-memory stack (PC restore
// on RET/RTI, with an optional leading flags beat for RTI) into one wide
// register and commits it atomically.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        begin a pop sequence (only honoured in IDLE)
//   with_flags   sampled with start: a flags beat precedes the PC beats
//   flush        abort any sequence in progress (wins over everything)
//   mem          stack_pop_if.master read port (mem_rd_en / mem_valid / mem_data)
//   sp_inc       registered pulse, one per accepted beat
//   busy         high whenever the FSM is not IDLE
//   done         registered pulse on the edge pc_out/flags_out are committed
//   flag_load    pulse with done when the sequence carried a flags beat
//   pc_out       last committed PC (BUS_W*NUM_BEATS bits)
//   flags_out    last committed flags (FLAG_W bits)
//   err          registered timeout pulse
//
// Build option: define STACK_POP_TIMEOUT_EN to abort a sequence after
// TIMEOUT_CYC consecutive wait cycles without an accepted beat. Without it,
// waits are unbounded and err is tied low.
// ---------------------------------------------------------------------------
module stack_pop_assembler #(
    parameter int BUS_W       = 16,
    parameter int NUM_BEATS   = 2,
    parameter int FLAG_W      = 3,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       with_flags,
    input  logic                       flush,
    stack_pop_if.master                mem,
    output logic                       sp_inc,
    output logic                       busy,
    output logic                       done,
    output logic                       flag_load,
    output logic [BUS_W*NUM_BEATS-1:0] pc_out,
    output logic [FLAG_W-1:0]          flags_out,
    output logic                       err
);
    localparam int PC_W  = BUS_W * NUM_BEATS;
    localparam int IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    if (NUM_BEATS < 1 || FLAG_W < 1 || FLAG_W > BUS_W || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("stack_pop_assembler: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLAGS  = 2'd1,
        S_BEATS  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx;
    logic [PC_W-1:0]   shadow;
    logic [FLAG_W-1:0] shadow_flags;
    logic              flag_seq;
    logic              waiting, accept, take, commit, timeout_hit;

    assign waiting       = (state == S_FLAGS) || (state == S_BEATS);
    assign mem.mem_rd_en = waiting;
    assign busy          = (state != S_IDLE);
    assign accept        = waiting && mem.mem_valid;
    // A beat arriving together with flush is dropped: nothing is written, SP is not bumped.
    assign take          = accept && !flush;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = with_flags ? S_FLAGS : S_BEATS;
            S_FLAGS:  if (accept) state_next = S_BEATS;
            S_BEATS:  if (accept && idx == '0) state_next = S_COMMIT;
            S_COMMIT: begin
                commit     = 1'b1;
                state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
        // Abort paths override the normal flow; in IDLE this is harmless and blocks a start.
        if (flush || timeout_hit) begin
            state_next = S_IDLE;
            commit     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            // NOTE: the shadow word is reset too, so a commit can never expose power-up garbage.
            shadow       <= '0;
            shadow_flags <= '0;
            flag_seq     <= 1'b0;
            pc_out       <= '0;
            flags_out    <= '0;
            sp_inc       <= 1'b0;
            done         <= 1'b0;
            flag_load    <= 1'b0;
        end else begin
            sp_inc    <= take;
            done      <= commit;
            flag_load <= commit && flag_seq;

            if (state == S_IDLE && state_next != S_IDLE)
                flag_seq <= with_flags;

            if (take && state == S_FLAGS)
                shadow_flags <= mem.mem_data[FLAG_W-1:0];

            // Words arrive most-significant first, so idx counts down from the top slot.
            if (take && state == S_BEATS)
                shadow[idx*BUS_W +: BUS_W] <= mem.mem_data;

            if (state_next == S_BEATS && state != S_BEATS)
                idx <= LAST_IDX;
            else if (take && state == S_BEATS && idx != '0)
                idx <= idx - 1'b1;

            if (commit) begin
                pc_out <= shadow;
                if (flag_seq) flags_out <= shadow_flags;
            end
        end
    end

`ifdef STACK_POP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // wait_cnt holds the number of completed empty wait cycles in the current beat.
    assign timeout_hit = waiting && !accept && !flush && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= timeout_hit;
            if (accept || state_next != state) wait_cnt <= '0;
            else if (waiting)                  wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule
